// File: rtl/ps2_pkg.sv
// PS/2 host bus controller shared definitions.
// State codes, default timing constants and a sizing helper.
package ps2_pkg;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RX      = 3'd1;
  localparam logic [2:0] S_INHIBIT = 3'd2;
  localparam logic [2:0] S_RTS     = 3'd3;
  localparam logic [2:0] S_TX      = 3'd4;

  localparam int INHIBIT_DEF = 5000;
  localparam int RTS_DEF     = 50;
  localparam int TIMEOUT_DEF = 750000;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ps2_timer.sv
// Saturating up-counter shared by phase timing and frame timeout.
// expire flags the cycle on which the count reaches limit.
module ps2_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         enable,
  input  logic [W-1:0] limit,
  output logic         expire
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = '0;
    else if (enable && cnt_q != '1)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  // one extra bit keeps cnt+1 from wrapping at the top of the range
  assign expire = ({1'b0, cnt_q} + 1'b1) >= {1'b0, limit};

endmodule

// File: rtl/ps2_bus_ctrl.sv
// PS/2 host bus arbiter: device frames, host inhibit/RTS/transmit
// sequencing and inter-edge timeout. Every output is a flop.
module ps2_bus_ctrl
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYC = INHIBIT_DEF,
  parameter int RTS_CYC     = RTS_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fall_edge,
  input  logic       tx_req,
  input  logic [7:0] tx_byte,
  input  logic       rx_done,
  input  logic [7:0] rx_byte,
  input  logic       trama_terminada,
  output logic       tx_ack,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       tx_idle,
  output logic       ps2_c_low,
  output logic       ps2_d_low,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       busy,
  output logic       timeout_err
);

  localparam int MAXC = max3(INHIBIT_CYC, RTS_CYC, TIMEOUT_CYC);
  localparam int W    = $clog2(MAXC + 1);

  localparam logic [W-1:0] INH_L = W'(INHIBIT_CYC);
  localparam logic [W-1:0] RTS_L = W'(RTS_CYC);
  localparam logic [W-1:0] TO_L  = W'(TIMEOUT_CYC);

  logic [2:0] state_q, state_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       ack_q, ack_d;
  logic       start_q, start_d;
  logic       rxv_q, rxv_d;
  logic       to_q, to_d;
  logic       c_low_q, c_low_d;
  logic       d_low_q, d_low_d;
  logic       idle_q, idle_d;
  logic       busy_q, busy_d;

  logic         tmr_load;
  logic         tmr_exp;
  logic [W-1:0] tmr_limit;

  always_comb begin
    tmr_limit = TO_L;
    if (state_q == S_INHIBIT) tmr_limit = INH_L;
    if (state_q == S_RTS)     tmr_limit = RTS_L;
  end

  ps2_timer #(.W(W)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (tmr_load),
    .enable (state_q != S_IDLE),
    .limit  (tmr_limit),
    .expire (tmr_exp)
  );

  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    rx_data_d = rx_data_q;
    ack_d     = 1'b0;
    start_d   = 1'b0;
    rxv_d     = 1'b0;
    to_d      = 1'b0;
    tmr_load  = 1'b0;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        // a device frame already in flight beats a host request
        if (fall_edge) begin
          state_d  = S_RX;
          tmr_load = 1'b1;
        end else if (tx_req) begin
          state_d   = S_INHIBIT;
          tx_data_d = tx_byte;
          ack_d     = 1'b1;
          tmr_load  = 1'b1;
        end
      end
      (state_q == S_RX): begin
        if (rx_done) begin
          state_d   = S_IDLE;
          rx_data_d = rx_byte;
          rxv_d     = 1'b1;
        end else if (fall_edge) begin
          tmr_load = 1'b1;
        end else if (tmr_exp) begin
          state_d = S_IDLE;
          to_d    = 1'b1;
        end
      end
      (state_q == S_INHIBIT): begin
        if (tmr_exp) begin
          state_d  = S_RTS;
          tmr_load = 1'b1;
        end
      end
      (state_q == S_RTS): begin
        if (tmr_exp) begin
          state_d  = S_TX;
          start_d  = 1'b1;
          tmr_load = 1'b1;
        end
      end
      (state_q == S_TX): begin
        if (trama_terminada) begin
          state_d = S_IDLE;
        end else if (fall_edge) begin
          tmr_load = 1'b1;
        end else if (tmr_exp) begin
          state_d = S_IDLE;
          to_d    = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    c_low_d = (state_d == S_INHIBIT);
    d_low_d = (state_d == S_RTS);
    idle_d  = (state_d == S_IDLE) || (state_d == S_RX);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      tx_data_q <= '0;
      rx_data_q <= '0;
      ack_q     <= 1'b0;
      start_q   <= 1'b0;
      rxv_q     <= 1'b0;
      to_q      <= 1'b0;
      c_low_q   <= 1'b0;
      d_low_q   <= 1'b0;
      idle_q    <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_data_q <= tx_data_d;
      rx_data_q <= rx_data_d;
      ack_q     <= ack_d;
      start_q   <= start_d;
      rxv_q     <= rxv_d;
      to_q      <= to_d;
      c_low_q   <= c_low_d;
      d_low_q   <= d_low_d;
      idle_q    <= idle_d;
      busy_q    <= busy_d;
    end
  end

  assign tx_ack      = ack_q;
  assign tx_start    = start_q;
  assign tx_data     = tx_data_q;
  assign tx_idle     = idle_q;
  assign ps2_c_low   = c_low_q;
  assign ps2_d_low   = d_low_q;
  assign rx_valid    = rxv_q;
  assign rx_data     = rx_data_q;
  assign busy        = busy_q;
  assign timeout_err = to_q;

endmodule

// File: tb/tb_ps2_bus_ctrl.sv
// Bench for ps2_bus_ctrl: deadline-based reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_ps2_bus_ctrl;

  localparam int INH  = 8;
  localparam int RTSC = 2;
  localparam int TOC  = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic       fe = 1'b0, req = 1'b0, rd = 1'b0, tt = 1'b0;
  logic [7:0] tb_byte = 8'h00, rb = 8'h00;

  logic       tx_ack, tx_start, tx_idle, ps2_c_low, ps2_d_low;
  logic       rx_valid, busy, timeout_err;
  logic [7:0] tx_data, rx_data;

  always #5 clk = ~clk;

  ps2_bus_ctrl #(
    .INHIBIT_CYC (INH),
    .RTS_CYC     (RTSC),
    .TIMEOUT_CYC (TOC)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .fall_edge       (fe),
    .tx_req          (req),
    .tx_byte         (tb_byte),
    .rx_done         (rd),
    .rx_byte         (rb),
    .trama_terminada (tt),
    .tx_ack          (tx_ack),
    .tx_start        (tx_start),
    .tx_data         (tx_data),
    .tx_idle         (tx_idle),
    .ps2_c_low       (ps2_c_low),
    .ps2_d_low       (ps2_d_low),
    .rx_valid        (rx_valid),
    .rx_data         (rx_data),
    .busy            (busy),
    .timeout_err     (timeout_err)
  );

  int tests = 0;
  int fails = 0;

  function automatic void chk(string nm, logic [31:0] act,
                              logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endfunction

  typedef enum {M_IDLE, M_RX, M_INH, M_RTS, M_TX} mode_t;

  mode_t      m_mode;
  int         m_n, m_dl;
  logic       e_ack, e_start, e_rxv, e_to;
  logic [7:0] e_txd, e_rxd;

  // Model: each phase ends at an absolute edge number (deadline)
  always @(posedge clk or negedge rst) begin : mdl
    mode_t      md;
    int         n1, dl;
    logic       a, s, v, t;
    logic [7:0] txd, rxd;
    if (!rst) begin
      m_mode  <= M_IDLE;
      m_n     <= 0;
      m_dl    <= 0;
      e_ack   <= 1'b0;
      e_start <= 1'b0;
      e_rxv   <= 1'b0;
      e_to    <= 1'b0;
      e_txd   <= 8'h00;
      e_rxd   <= 8'h00;
    end else begin
      n1 = m_n + 1;
      md = m_mode;
      dl = m_dl;
      a = 1'b0; s = 1'b0; v = 1'b0; t = 1'b0;
      txd = e_txd;
      rxd = e_rxd;
      case (m_mode)
        M_IDLE:
          if (fe) begin md = M_RX; dl = n1 + TOC; end
          else if (req) begin
            a = 1'b1; txd = tb_byte; md = M_INH; dl = n1 + INH;
          end
        M_RX:
          if (rd) begin rxd = rb; v = 1'b1; md = M_IDLE; end
          else if (fe) dl = n1 + TOC;
          else if (n1 == dl) begin t = 1'b1; md = M_IDLE; end
        M_INH:
          if (n1 == dl) begin md = M_RTS; dl = n1 + RTSC; end
        M_RTS:
          if (n1 == dl) begin md = M_TX; s = 1'b1; dl = n1 + TOC; end
        M_TX:
          if (tt) md = M_IDLE;
          else if (fe) dl = n1 + TOC;
          else if (n1 == dl) begin t = 1'b1; md = M_IDLE; end
        default: md = M_IDLE;
      endcase
      m_n     <= n1;
      m_mode  <= md;
      m_dl    <= dl;
      e_ack   <= a;
      e_start <= s;
      e_rxv   <= v;
      e_to    <= t;
      e_txd   <= txd;
      e_rxd   <= rxd;
    end
  end

  logic [23:0] act_v, exp_v;
  always_comb begin
    act_v = {tx_ack, tx_start, tx_data, tx_idle, ps2_c_low,
             ps2_d_low, rx_valid, rx_data, busy, timeout_err};
    exp_v = {e_ack, e_start, e_txd,
             (m_mode == M_IDLE) || (m_mode == M_RX),
             m_mode == M_INH, m_mode == M_RTS, e_rxv, e_rxd,
             m_mode != M_IDLE, e_to};
  end

  always @(negedge clk) chk("cycle_model", 32'(act_v), 32'(exp_v));

  // Cycle counts of each output being high (pre-edge values)
  int c_ack = 0, c_start = 0, c_clow = 0, c_dlow = 0;
  int c_rxv = 0, c_to = 0, c_nidle = 0;
  always @(posedge clk) begin
    c_ack   <= c_ack   + int'(tx_ack);
    c_start <= c_start + int'(tx_start);
    c_clow  <= c_clow  + int'(ps2_c_low);
    c_dlow  <= c_dlow  + int'(ps2_d_low);
    c_rxv   <= c_rxv   + int'(rx_valid);
    c_to    <= c_to    + int'(timeout_err);
    c_nidle <= c_nidle + int'(!tx_idle);
  end

  task automatic cyc(input int k);
    repeat (k) @(negedge clk);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int s_ack, s_start, s_clow, s_dlow, s_rxv, s_to, s_nidle;
    rst = 1'b1;
    #1 rst = 1'b0;
    cyc(2);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tx_idle", 32'(tx_idle), 32'd1);
    chk("rst_lines", 32'({ps2_c_low, ps2_d_low}), 32'd0);
    chk("rst_data", 32'({tx_data, rx_data}), 32'd0);
    rst = 1'b1;
    cyc(2);

    // transmit 0xED
    s_ack = c_ack; s_start = c_start; s_clow = c_clow; s_dlow = c_dlow;
    tb_byte = 8'hED; req = 1'b1;
    cyc(1);
    req = 1'b0;
    chk("t29_ack", 32'(tx_ack), 32'd1);
    chk("t29_clow_now", 32'(ps2_c_low), 32'd1);
    cyc(12);
    chk("t29_ack_cnt", 32'(c_ack - s_ack), 32'd1);
    chk("t29_clow_cyc", 32'(c_clow - s_clow), 32'd8);
    chk("t29_dlow_cyc", 32'(c_dlow - s_dlow), 32'd2);
    chk("t29_start_cnt", 32'(c_start - s_start), 32'd1);
    chk("t29_tx_data", 32'(tx_data), 32'hED);
    chk("t29_in_tx", 32'({busy, tx_idle}), 32'b10);
    tt = 1'b1;
    cyc(1);
    tt = 1'b0;
    chk("t29_done_idle", 32'(busy), 32'd0);

    // receive 0x1C after 11 edges
    s_rxv = c_rxv; s_nidle = c_nidle;
    for (int i = 0; i < 11; i++) begin
      fe = 1'b1; cyc(1); fe = 1'b0; cyc(2);
    end
    rb = 8'h1C; rd = 1'b1;
    cyc(1);
    rd = 1'b0;
    chk("t30_rx_valid", 32'(rx_valid), 32'd1);
    chk("t30_rx_data", 32'(rx_data), 32'h1C);
    cyc(1);
    chk("t30_rxv_cnt", 32'(c_rxv - s_rxv), 32'd1);
    chk("t30_tx_idle_low", 32'(c_nidle - s_nidle), 32'd0);

    // collision: device frame wins, request served afterwards
    s_ack = c_ack; s_start = c_start; s_clow = c_clow; s_dlow = c_dlow;
    tb_byte = 8'hED; fe = 1'b1; req = 1'b1;
    cyc(1);
    fe = 1'b0;
    chk("t31_rx_entered", 32'({busy, tx_idle, tx_ack}), 32'b110);
    for (int i = 0; i < 10; i++) begin
      cyc(2); fe = 1'b1; cyc(1); fe = 1'b0;
    end
    chk("t31_no_ack_busy", 32'(c_ack - s_ack), 32'd0);
    rb = 8'hAA; rd = 1'b1;
    cyc(1);
    rd = 1'b0;
    chk("t31_rx_data", 32'({rx_valid, rx_data}), 32'h1AA);
    chk("t31_ack_late", 32'(tx_ack), 32'd0);
    cyc(1);
    chk("t31_ack", 32'(tx_ack), 32'd1);
    req = 1'b0;
    cyc(11);
    chk("t31_ack_cnt", 32'(c_ack - s_ack), 32'd1);
    chk("t31_clow_cyc", 32'(c_clow - s_clow), 32'd8);
    chk("t31_dlow_cyc", 32'(c_dlow - s_dlow), 32'd2);
    chk("t31_start_cnt", 32'(c_start - s_start), 32'd1);
    tt = 1'b1; cyc(1); tt = 1'b0;

    // transmit timeout; edge during inhibit ignored
    s_to = c_to;
    tb_byte = 8'h55; req = 1'b1;
    cyc(1);
    req = 1'b0;
    cyc(3);
    fe = 1'b1; cyc(1); fe = 1'b0;
    cyc(30);
    chk("t32_to_cnt", 32'(c_to - s_to), 32'd1);
    chk("t32_released", 32'({busy, ps2_c_low, ps2_d_low}), 32'd0);
    chk("t32_tx_idle", 32'(tx_idle), 32'd1);
    chk("t32_tx_data", 32'(tx_data), 32'h55);
    tt = 1'b1; cyc(1); tt = 1'b0;
    chk("t32_tt_ignored", 32'(busy), 32'd0);
    rb = 8'h77; rd = 1'b1; cyc(1); rd = 1'b0;
    chk("t32_rd_ignored", 32'({rx_valid, rx_data}), 32'h0AA);

    // asynchronous reset in the middle of inhibit
    req = 1'b1;
    cyc(1);
    req = 1'b0;
    cyc(3);
    chk("t33_in_inhibit", 32'(ps2_c_low), 32'd1);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("t33_async_clow", 32'(ps2_c_low), 32'd0);
    chk("t33_async_state", 32'({busy, tx_idle}), 32'b01);
    chk("t33_async_data", 32'(tx_data), 32'h00);
    cyc(2);
    rst = 1'b1;
    cyc(2);
    chk("t33_after_idle", 32'({busy, tx_idle, ps2_c_low}), 32'b010);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
